// File: rtl/instructie_sequencer.sv
// ---------------------------------------------------------------------------
// instructie_sequencer
//
// Control unit for the fetch/decode/execute cycle around the negedge-registered
// instruction decoder. It fetches a word from program memory over a req/ack
// handshake and holds it in the instruction register that feeds the decoder.
// The decoder then gets one full cycle, after which the execute stage is
// started and supervised. When the execute stage finishes, the program counter
// is incremented, loaded with a jump target, or held for a halt. An execute
// stage that never finishes is caught by a timeout.
//
// Ports:
//   clock        in   system clock, all state changes on posedge
//   reset_n      in   asynchronous active-low reset
//   start        in   begin execution (honoured in IDLE or HALT only)
//   mem_req      out  fetch request to program memory
//   mem_addr     out  fetch address, always equal to pc
//   mem_ack      in   mem_data is valid this cycle
//   mem_data     in   fetched instruction word
//   instructie   out  instruction register, drives the decoder input
//   exec_start   out  one-cycle pulse: execute the decoded instruction
//   exec_done    in   execute stage finished
//   jump_valid   in   with exec_done: load jump_target into pc
//   jump_target  in   jump destination
//   halt_req     in   with exec_done: the instruction was HALT
//   pc           out  program counter
//   busy         out  high in FETCH, DECODE and EXECUTE
//   halted       out  high in HALT
//   fault        out  sticky execute-timeout flag
//   instr_count  out  retired instructions, saturating
// ---------------------------------------------------------------------------
module instructie_sequencer #(
  parameter int PC_WIDTH     = 8,
  parameter int INSTR_WIDTH  = 9,
  parameter int EXEC_TIMEOUT = 15,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   mem_req,
  output logic [PC_WIDTH-1:0]    mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  output logic [INSTR_WIDTH-1:0] instructie,
  output logic                   exec_start,
  input  logic                   exec_done,
  input  logic                   jump_valid,
  input  logic [PC_WIDTH-1:0]    jump_target,
  input  logic                   halt_req,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   busy,
  output logic                   halted,
  output logic                   fault,
  output logic [CNT_WIDTH-1:0]   instr_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  // Timeout counter holds 0..EXEC_TIMEOUT-1 (value = EXECUTE cycles already
  // finished without exec_done).
  localparam int TMO_W = (EXEC_TIMEOUT < 2) ? 1 : $clog2(EXEC_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(EXEC_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]     TMO_ONE  = TMO_W'(1);
  localparam logic [PC_WIDTH-1:0]  PC_ONE   = PC_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic [2:0]             state_r;
  logic [PC_WIDTH-1:0]    pc_r;
  logic [INSTR_WIDTH-1:0] instructie_r;
  logic [CNT_WIDTH-1:0]   instr_count_r;
  logic [TMO_W-1:0]       tmo_cnt_r;
  logic                   mem_req_r;
  logic                   exec_start_r;
  logic                   halted_r;
  logic                   fault_r;

  // Sequencer state machine together with all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= '0;
      instructie_r  <= '0;
      instr_count_r <= '0;
      tmo_cnt_r     <= '0;
      mem_req_r     <= 1'b0;
      exec_start_r  <= 1'b0;
      halted_r      <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          exec_start_r <= 1'b0;
          if (start) begin
            state_r   <= ST_FETCH;
            mem_req_r <= 1'b1;
          end
        end
        ST_FETCH: begin
          // Wait for the ack as long as it takes.
          if (mem_ack) begin
            instructie_r <= mem_data;
            mem_req_r    <= 1'b0;
            state_r      <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          // instructie is stable for this whole cycle, so the decoder latches
          // it on the negedge; execution starts the cycle after.
          state_r      <= ST_EXECUTE;
          exec_start_r <= 1'b1;
          tmo_cnt_r    <= '0;
        end
        ST_EXECUTE: begin
          exec_start_r <= 1'b0;
          if (exec_done) begin
            // A done arriving on the limit cycle still retires normally.
            if (instr_count_r != CNT_MAX) begin
              instr_count_r <= instr_count_r + CNT_ONE;
            end
            if (halt_req) begin
              state_r  <= ST_HALT;
              halted_r <= 1'b1;
            end else begin
              if (jump_valid) begin
                pc_r <= jump_target;
              end else begin
                pc_r <= pc_r + PC_ONE;
              end
              state_r   <= ST_FETCH;
              mem_req_r <= 1'b1;
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            fault_r  <= 1'b1;
            halted_r <= 1'b1;
            state_r  <= ST_HALT;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
          end
        end
        ST_HALT: begin
          // Restart from address 0 with fresh status.
          if (start) begin
            halted_r      <= 1'b0;
            fault_r       <= 1'b0;
            pc_r          <= '0;
            instr_count_r <= '0;
            state_r       <= ST_FETCH;
            mem_req_r     <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          mem_req_r    <= 1'b0;
          exec_start_r <= 1'b0;
          halted_r     <= 1'b0;
        end
      endcase
    end
  end

  // busy is a pure decode of the active states.
  always_comb begin
    busy = 1'b0;
    case (state_r)
      ST_FETCH, ST_DECODE, ST_EXECUTE: busy = 1'b1;
      default:                         busy = 1'b0;
    endcase
  end

  assign mem_addr    = pc_r;
  assign pc          = pc_r;
  assign mem_req     = mem_req_r;
  assign instructie  = instructie_r;
  assign exec_start  = exec_start_r;
  assign halted      = halted_r;
  assign fault       = fault_r;
  assign instr_count = instr_count_r;

endmodule

// File: tb/tb_instructie_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instructie_sequencer
//
// Directed bench for instructie_sequencer: drives inputs on the negedge,
// checks registered outputs on the following negedge against hand-tracked
// expected pc / retirement count and constants.
// ---------------------------------------------------------------------------
module tb_instructie_sequencer;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [8:0] mem_data;
  logic [8:0] instructie;
  logic       exec_start;
  logic       exec_done;
  logic       jump_valid;
  logic [7:0] jump_target;
  logic       halt_req;
  logic [7:0] pc;
  logic       busy;
  logic       halted;
  logic       fault;
  logic [15:0] instr_count;

  logic [8:0] mem [256];
  logic [7:0] exp_pc;
  logic [15:0] exp_cnt;
  int n_vec;
  int n_err;

  instructie_sequencer #(
    .PC_WIDTH(8), .INSTR_WIDTH(9), .EXEC_TIMEOUT(15), .CNT_WIDTH(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .instructie(instructie), .exec_start(exec_start),
    .exec_done(exec_done), .jump_valid(jump_valid), .jump_target(jump_target),
    .halt_req(halt_req), .pc(pc), .busy(busy), .halted(halted),
    .fault(fault), .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Program memory model: words 0..3 equal their address, others are tagged.
  assign mem_data = mem[mem_addr];

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, returning on the following negedge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req"},   32'(mem_req),     32'd0);
    check_val({tag, "_xs"},    32'(exec_start),  32'd0);
    check_val({tag, "_busy"},  32'(busy),        32'd0);
    check_val({tag, "_halt"},  32'(halted),      32'd0);
    check_val({tag, "_fault"}, 32'(fault),       32'd0);
    check_val({tag, "_pc"},    32'(pc),          32'd0);
    check_val({tag, "_addr"},  32'(mem_addr),    32'd0);
    check_val({tag, "_ir"},    32'(instructie),  32'd0);
    check_val({tag, "_cnt"},   32'(instr_count), 32'd0);
  endtask

  // From FETCH (mem_req high) run one instruction with zero-wait ack and a
  // same-cycle exec_done carrying the given jump/halt qualifiers.
  task automatic run_instr(input logic jv, input logic [7:0] jt, input logic hr);
    mem_ack = 1'b1;
    tick();
    check_val("ir_load",   32'(instructie), 32'(mem[exp_pc]));
    check_val("req_drop",  32'(mem_req),    32'd0);
    check_val("xs_decode", 32'(exec_start), 32'd0);
    tick();
    check_val("xs_pulse",  32'(exec_start), 32'd1);
    check_val("busy_exec", 32'(busy),       32'd1);
    exec_done   = 1'b1;
    jump_valid  = jv;
    jump_target = jt;
    halt_req    = hr;
    tick();
    exec_done  = 1'b0;
    jump_valid = 1'b0;
    halt_req   = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    if (!hr) begin
      exp_pc = jv ? jt : exp_pc + 8'd1;
    end
    check_val("xs_end",  32'(exec_start),  32'd0);
    check_val("pc",      32'(pc),          32'(exp_pc));
    check_val("cnt",     32'(instr_count), 32'(exp_cnt));
    check_val("req_nxt", 32'(mem_req),     32'(!hr));
    check_val("halted",  32'(halted),      32'(hr));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = (i < 4) ? 9'(i) : (9'h100 | 9'(i));
    end
    reset_n = 1'b0; start = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
    jump_valid = 1'b0; jump_target = 8'h00; halt_req = 1'b0;
    exp_pc = 8'h00; exp_cnt = 16'd0;

    // Reset state
    tick(); tick();
    check_all_zero("rst");
    reset_n = 1'b1;
    tick();
    check_val("idle_req", 32'(mem_req), 32'd0);

    // Start from IDLE
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("start_req",  32'(mem_req),  32'd1);
    check_val("start_busy", 32'(busy),     32'd1);
    check_val("start_addr", 32'(mem_addr), 32'd0);

    // Back-to-back instructions 0..3; the last one jumps to 8'h40
    for (int i = 0; i < 4; i++) begin
      run_instr(i == 3, 8'h40, 1'b0);
    end
    check_val("jump_addr", 32'(mem_addr), 32'h40);
    check_val("cnt4",      32'(instr_count), 32'd4);
    run_instr(1'b1, 8'h05, 1'b0);

    // Wait states at pc=5
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("ws_req",  32'(mem_req),    32'd1);
      check_val("ws_addr", 32'(mem_addr),   32'h05);
      check_val("ws_ir",   32'(instructie), 32'(mem[8'h40]));
      check_val("ws_xs",   32'(exec_start), 32'd0);
    end
    run_instr(1'b1, 8'hFF, 1'b0);

    // Wrap at all-ones, then jump to 7 and halt there with jump also set
    run_instr(1'b0, 8'h00, 1'b0);
    check_val("wrap_pc", 32'(pc), 32'h00);
    run_instr(1'b1, 8'h07, 1'b0);
    run_instr(1'b1, 8'h20, 1'b1);
    check_val("halt_pc",   32'(pc),   32'h07);
    check_val("halt_busy", 32'(busy), 32'd0);
    tick();
    check_val("halt_hold", 32'(halted), 32'd1);
    check_val("halt_req0", 32'(mem_req), 32'd0);

    // Restart from HALT
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_pc = 8'h00; exp_cnt = 16'd0;
    check_val("rs_pc",   32'(pc),          32'd0);
    check_val("rs_halt", 32'(halted),      32'd0);
    check_val("rs_cnt",  32'(instr_count), 32'd0);
    check_val("rs_req",  32'(mem_req),     32'd1);

    // Execute timeout: no exec_done at all
    mem_ack = 1'b1;
    tick(); tick();
    check_val("to_xs", 32'(exec_start), 32'd1);
    for (int i = 0; i < 14; i++) tick();
    check_val("to_nf14", 32'(fault), 32'd0);
    check_val("to_bz14", 32'(busy),  32'd1);
    tick();
    check_val("to_fault", 32'(fault),       32'd1);
    check_val("to_halt",  32'(halted),      32'd1);
    check_val("to_pc",    32'(pc),          32'd0);
    check_val("to_cnt",   32'(instr_count), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("to_clr", 32'(fault), 32'd0);

    // exec_done on the 15th EXECUTE cycle wins over the timeout
    tick(); tick();
    for (int i = 0; i < 14; i++) tick();
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check_val("lim_fault", 32'(fault),       32'd0);
    check_val("lim_pc",    32'(pc),          32'd1);
    check_val("lim_cnt",   32'(instr_count), 32'd1);

    // Asynchronous reset mid-FETCH, then late ack is ignored
    mem_ack = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_all_zero("arf");
    @(negedge clock);
    reset_n = 1'b1;
    mem_ack = 1'b1;
    tick(); tick(); tick();
    check_val("late_req",  32'(mem_req),    32'd0);
    check_val("late_busy", 32'(busy),       32'd0);
    check_val("late_ir",   32'(instructie), 32'd0);

    // Asynchronous reset mid-EXECUTE
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_pc = 8'h00; exp_cnt = 16'd0;
    run_instr(1'b0, 8'h00, 1'b0);
    tick(); tick();
    check_val("are_xs1", 32'(exec_start), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("are");
    @(negedge clock);
    reset_n = 1'b1;
    mem_ack = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
